// File: rtl/display_read_port.sv
// Back-door read port: credit-limited line requests to memory, 128-bit return beats packed to 96-bit RD.
// Define DISP_RB_SWAP_EN to pack pixels as {b,g,r} for BGR-ordered framebuffers.
module display_read_port #(
    parameter int MAX_OUT = 8,
    parameter int BEATS   = 2
) (
    input  logic         clock,
    input  logic         resetB,
    input  logic         readReq,
    input  logic [25:0]  RA,
    output logic         readAck,
    output logic         cmdValid,
    output logic [25:0]  cmdAddr,
    input  logic         cmdReady,
    input  logic         rdValid,
    input  logic [127:0] rdData,
    output logic [95:0]  RD,
    output logic         RDready,
    output logic         overrun
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0]        OUT_LIMIT = 4'(MAX_OUT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    state_t            stateNext;
    logic [3:0]        outCnt;
    logic [BEAT_W-1:0] beatCnt;
    logic              beatAccept;
    logic              lastBeat;
    logic [95:0]       packedPix;
    logic [31:0]       droppedBytes;
    logic              unusedBytes;

    // A beat only counts against a line if one is actually outstanding.
    assign beatAccept = rdValid && (outCnt != 4'd0);
    assign lastBeat   = beatAccept && (beatCnt == LAST_BEAT);
    assign cmdValid   = (state == ISSUE);

    always_comb begin
        stateNext = state;
        readAck   = 1'b0;
        case (state)
            IDLE: begin
                if (resetB && readReq && (outCnt < OUT_LIMIT)) begin
                    readAck   = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (cmdReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetB) begin
        if (!resetB) begin
            state   <= IDLE;
            cmdAddr <= '0;
        end else begin
            state <= stateNext;
            if (readAck) begin
                cmdAddr <= RA;
            end
        end
    end

    always_ff @(posedge clock or negedge resetB) begin
        if (!resetB) begin
            outCnt <= '0;
        end else begin
            case ({readAck, lastBeat})
                2'b10:   outCnt <= outCnt + 4'd1;
                2'b01:   outCnt <= outCnt - 4'd1;
                default: outCnt <= outCnt;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetB) begin
        if (!resetB) begin
            beatCnt <= '0;
            RD      <= '0;
            RDready <= 1'b0;
            overrun <= 1'b0;
        end else begin
            RDready <= beatAccept;
            if (beatAccept) begin
                RD      <= packedPix;
                beatCnt <= lastBeat ? '0 : beatCnt + BEAT_W'(1);
            end
            if (rdValid && (outCnt == 4'd0)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Each 32-bit word is {pad, r, g, b}; the pad byte is discarded.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gPack
            logic [31:0] word;
            assign word = rdData[32*gi +: 32];
`ifdef DISP_RB_SWAP_EN
            assign packedPix[24*gi +: 24] = {word[7:0], word[15:8], word[23:16]};
`else
            assign packedPix[24*gi +: 24] = word[23:0];
`endif
            assign droppedBytes[8*gi +: 8] = word[31:24];
        end
    endgenerate

    assign unusedBytes = ^droppedBytes;

endmodule
